// File: rtl/input_conditioner_pkg.sv
// Shared types and defaults for the input conditioner.
// Channel FSM states plus default synchronizer/debounce depths.
package input_conditioner_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One conditioned channel: synchronizer, debounce FSM,
// clean level and registered edge pulses.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W =
    $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   sync;
  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   clean_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   flip;

  assign sync  = chain_q[SYNC_STAGES-1];
  assign clean = clean_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flip    = 1'b0;
    unique case (state_q)
      STABLE: begin
        if (sync != clean_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            flip = 1'b1;
          end else begin
            state_d = PENDING;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      PENDING: begin
        if (sync == clean_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q ==
                     CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          // this edge is the DEBOUNCE_CYCLES-th mismatch
          flip    = 1'b1;
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
      state_q <= STABLE;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_q ^ flip;
      rise_q  <= flip & ~clean_q;
      fall_q  <= flip & clean_q;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Conditions asynchronous board inputs into clean levels,
// edge pulses and a post-reset settled flag.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W =
    $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             settled
);

  localparam int unsigned FILL =
    SYNC_STAGES + DEBOUNCE_CYCLES;
  localparam int unsigned FW = $clog2(FILL + 1);

  logic [FW-1:0] fill_q;
  logic          settled_q;

  assign settled = settled_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_in[i]),
      .clean(clean_out[i]),
      .rise (rise_pulse[i]),
      .fall (fall_pulse[i])
    );
  end

  // fill counter freezes once settled
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q    <= '0;
      settled_q <= 1'b0;
    end else if (!settled_q) begin
      fill_q    <= fill_q + FW'(1);
      settled_q <= (fill_q == FW'(FILL - 1));
    end
  end

endmodule
